// File: rtl/ex_unit.sv
// ex_unit: RV32I execute stage with serial/barrel shifter, load wait and jump redirect
module ex_unit #(
  parameter int SERIAL_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  oh,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] ins,
  input  logic [31:0] ins_addr,
  input  logic [4:0]  rd_addr,
  input  logic        rd_wen,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_wen,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD_WAIT} state_t;
  state_t state, state_nx;
  logic [4:0] cnt, p_rd;
  logic [31:0] shreg, sh_nx, res, tgt, ld_res, j_imm, b_imm;
  logic [6:0] ld_op;
  logic s_left, s_arith, p_wen;
  logic accept, is_shift, is_load, serial, writes, taken, lt, ltu, do_jump;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic unused_ok;
  assign unused_ok = ^ins[6:0];
  always_comb begin
    in_ready = state == IDLE;
    accept   = in_valid && !jump_en && state == IDLE;
    is_shift = oh inside {7'd25, 7'd26, 7'd27, 7'd30, 7'd34, 7'd35};
    is_load  = oh inside {[7'd11:7'd15]};
    serial   = SERIAL_SHIFT != 0 && is_shift && op2[4:0] != 5'd0;
    writes   = oh inside {[7'd1:7'd4], [7'd11:7'd15], [7'd19:7'd37]};
    lt       = $signed(op1) < $signed(op2);
    ltu      = op1 < op2;
    taken    = (oh == 7'd5 && op1 == op2) || (oh == 7'd6 && op1 != op2) ||
               (oh == 7'd7 && lt) || (oh == 7'd8 && !lt) ||
               (oh == 7'd9 && ltu) || (oh == 7'd10 && !ltu);
    do_jump  = taken || oh == 7'd3 || oh == 7'd4;
    j_imm    = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    b_imm    = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    tgt      = oh == 7'd3 ? ins_addr + j_imm :
               oh == 7'd4 ? (op1 + op2) & ~32'd1 : ins_addr + b_imm;
    res = 32'd0;
    case (oh)
      7'd1:          res = op1;
      7'd2:          res = op1 + ins_addr;
      7'd3, 7'd4:    res = ins_addr + 32'd4;
      7'd19, 7'd28:  res = op1 + op2;
      7'd29:         res = op1 - op2;
      7'd20, 7'd31:  res = {31'd0, lt};
      7'd21, 7'd32:  res = {31'd0, ltu};
      7'd22, 7'd33:  res = op1 ^ op2;
      7'd23, 7'd36:  res = op1 | op2;
      7'd24, 7'd37:  res = op1 & op2;
      7'd25, 7'd30:  res = op1 << op2[4:0];
      7'd26, 7'd34:  res = op1 >> op2[4:0];
      7'd27, 7'd35:  res = $unsigned($signed(op1) >>> op2[4:0]);
      default:       res = 32'd0;
    endcase
    sh_nx  = s_left ? {shreg[30:0], 1'b0} : {s_arith & shreg[31], shreg[31:1]};
    bsel   = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
    hsel   = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_res = ld_op == 7'd11 ? {{24{bsel[7]}}, bsel} :
             ld_op == 7'd12 ? {{16{hsel[15]}}, hsel} :
             ld_op == 7'd14 ? {24'd0, bsel} :
             ld_op == 7'd15 ? {16'd0, hsel} : mem_rdata;
    state_nx = state;
    case (state)
      IDLE:      state_nx = accept && is_load ? LOAD_WAIT : accept && serial ? SHIFT : IDLE;
      SHIFT:     state_nx = cnt == 5'd1 ? IDLE : SHIFT;
      LOAD_WAIT: state_nx = mem_rvalid ? IDLE : LOAD_WAIT;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr <= '0; wb_data <= '0; wb_wen <= 1'b0; jump_en <= 1'b0; jump_addr <= '0;
      mem_req <= 1'b0; mem_addr <= '0; cnt <= '0; shreg <= '0; s_left <= 1'b0;
      s_arith <= 1'b0; p_rd <= '0; p_wen <= 1'b0; ld_op <= '0;
    end else begin
      wb_wen  <= 1'b0;
      jump_en <= 1'b0;
      mem_req <= 1'b0;
      if (accept) begin
        p_rd  <= rd_addr;
        p_wen <= rd_wen && rd_addr != 5'd0;
        ld_op <= oh;
      end
      if (accept && is_load) begin
        mem_req  <= 1'b1;
        mem_addr <= op1 + {{20{ins[31]}}, ins[31:20]};
      end else if (accept && serial) begin
        shreg   <= op1;
        cnt     <= op2[4:0];
        s_left  <= oh == 7'd25 || oh == 7'd30;
        s_arith <= oh == 7'd27 || oh == 7'd35;
      end else if (accept) begin
        wb_addr <= rd_addr;
        wb_data <= res;
        wb_wen  <= rd_wen && rd_addr != 5'd0 && writes;
        jump_en <= do_jump;
        if (do_jump) jump_addr <= tgt;
      end
      if (state == SHIFT) begin
        shreg <= sh_nx;
        cnt   <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          wb_addr <= p_rd;
          wb_data <= sh_nx;
          wb_wen  <= p_wen;
        end
      end
      if (state == LOAD_WAIT && mem_rvalid) begin
        wb_addr <= p_rd;
        wb_data <= ld_res;
        wb_wen  <= p_wen;
      end
    end
  end
endmodule
